// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - Multicycle MIPS control FSM with memory wait-state timeout
module mips_mc_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] pc_src,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [3:0] state,
    output logic       error
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        IEXEC  = 4'd10,
        IWB    = 4'd11,
        JR     = 4'd12,
        JAL    = 4'd13,
        ERROR  = 4'd15
    } state_t;

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(MEM_TIMEOUT - 1);

    state_t         cur;
    state_t         nxt;
    logic [CW-1:0]  wait_cnt;
    logic           timeout;
    logic           cur_wait;
    logic           nxt_wait;

    assign state    = cur;
    // The wait that would bring the counter to MEM_TIMEOUT is the last one allowed.
    assign timeout  = (wait_cnt == TO_LAST);
    assign cur_wait = (cur == FETCH) || (cur == MEMRD) || (cur == MEMWR);
    assign nxt_wait = (nxt == FETCH) || (nxt == MEMRD) || (nxt == MEMWR);

    always_comb begin
        nxt = cur;
        case (cur)
            FETCH: begin
                if (mem_ready)    nxt = DECODE;
                else if (timeout) nxt = ERROR;
            end
            DECODE: begin
                case (opcode)
                    6'h00:        nxt = (funct == 6'h08) ? JR : EXEC;
                    6'h23, 6'h2B: nxt = MEMADR;
                    6'h04, 6'h05: nxt = BRANCH;
                    6'h02:        nxt = JUMP;
                    6'h03:        nxt = JAL;
                    6'h08, 6'h09, 6'h0A, 6'h0B,
                    6'h0C, 6'h0D, 6'h0E, 6'h0F: nxt = IEXEC;
                    default:      nxt = ERROR;
                endcase
            end
            MEMADR: nxt = (opcode == 6'h23) ? MEMRD : MEMWR;
            MEMRD: begin
                if (mem_ready)    nxt = MEMWB;
                else if (timeout) nxt = ERROR;
            end
            MEMWR: begin
                if (mem_ready)    nxt = FETCH;
                else if (timeout) nxt = ERROR;
            end
            EXEC:   nxt = ALUWB;
            IEXEC:  nxt = IWB;
            MEMWB, ALUWB, IWB, BRANCH, JUMP, JR, JAL: nxt = FETCH;
            ERROR:  nxt = ERROR;
            default: nxt = ERROR;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur      <= FETCH;
            wait_cnt <= '0;
            error    <= 1'b0;
        end else begin
            cur   <= nxt;
            error <= error | (nxt == ERROR);
            if (nxt_wait && (nxt != cur))
                wait_cnt <= '0;
            else if (cur_wait && !mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        pc_src     = 2'b00;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (cur)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // Gated by reset so no PC/IR update can leak out while reset is high.
                if (mem_ready && !reset) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            DECODE: alu_src_b = 2'b11;
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
            end
            MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
            end
            IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
            end
            IWB: reg_write = 1'b1;
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_write  = ((opcode == 6'h04) && zero) || ((opcode == 6'h05) && !zero);
            end
            JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
            end
            JR: begin
                pc_write = 1'b1;
                pc_src   = 2'b11;
            end
            JAL: begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb/tb_mips_mc_ctrl.sv - Self-checking bench for mips_mc_ctrl
module tb_mips_mc_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write, alu_src_a;
    logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op;
    logic [3:0] state;
    logic       error;
    logic [16:0] ctl;

    int n_checks = 0;
    int n_fail = 0;

    mips_mc_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .pc_src(pc_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .error(error)
    );

    always #5 clock = ~clock;

    // {pc_write, ir_write, iord, mem_read, mem_write, reg_write, alu_src_a, pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op}
    assign ctl = {pc_write, ir_write, iord, mem_read, mem_write, reg_write, alu_src_a,
                  pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op};

    typedef struct {
        string          name;
        logic [5:0]     op;
        logic [5:0]     fn;
        logic           z;
        int             len;
        logic [4:0][3:0] seq;
        logic [3:0]     after;
        logic [16:0]    ctl;
    } vec_t;

    vec_t vt[13];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [5:0] op, input logic [5:0] fn,
                                input logic z, input int len,
                                input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                                input logic [3:0] s3, input logic [3:0] s4,
                                input logic [3:0] after, input logic [16:0] c);
        vec_t v;
        v.name = name; v.op = op; v.fn = fn; v.z = z; v.len = len;
        v.seq = {s4, s3, s2, s1, s0};
        v.after = after; v.ctl = c;
        return v;
    endfunction

    task automatic start();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] lw_seq [9];
        logic       lw_rdy [9];

        vt[0]  = mk("add",   6'h00, 6'h20, 1'b0, 4, 0, 1, 6, 7, 0,  0, 17'b0000010_00_01_00_00_00);
        vt[1]  = mk("jr",    6'h00, 6'h08, 1'b0, 3, 0, 1, 12, 0, 0, 0, 17'b1000000_11_00_00_00_00);
        vt[2]  = mk("lw",    6'h23, 6'h00, 1'b0, 5, 0, 1, 2, 3, 4,  0, 17'b0000010_00_00_01_00_00);
        vt[3]  = mk("sw",    6'h2B, 6'h00, 1'b0, 4, 0, 1, 2, 5, 0,  0, 17'b0010100_00_00_00_00_00);
        vt[4]  = mk("beq_z1",6'h04, 6'h00, 1'b1, 3, 0, 1, 8, 0, 0,  0, 17'b1000001_01_00_00_00_01);
        vt[5]  = mk("beq_z0",6'h04, 6'h00, 1'b0, 3, 0, 1, 8, 0, 0,  0, 17'b0000001_01_00_00_00_01);
        vt[6]  = mk("bne_z0",6'h05, 6'h00, 1'b0, 3, 0, 1, 8, 0, 0,  0, 17'b1000001_01_00_00_00_01);
        vt[7]  = mk("bne_z1",6'h05, 6'h00, 1'b1, 3, 0, 1, 8, 0, 0,  0, 17'b0000001_01_00_00_00_01);
        vt[8]  = mk("j",     6'h02, 6'h00, 1'b0, 3, 0, 1, 9, 0, 0,  0, 17'b1000000_10_00_00_00_00);
        vt[9]  = mk("jal",   6'h03, 6'h00, 1'b0, 3, 0, 1, 13, 0, 0, 0, 17'b1000010_10_10_10_00_00);
        vt[10] = mk("addi",  6'h08, 6'h00, 1'b0, 4, 0, 1, 10, 11, 0, 0, 17'b0000010_00_00_00_00_00);
        vt[11] = mk("ori",   6'h0D, 6'h00, 1'b0, 4, 0, 1, 10, 11, 0, 0, 17'b0000010_00_00_00_00_00);
        vt[12] = mk("bad_op",6'h3F, 6'h00, 1'b0, 3, 0, 1, 15, 0, 0, 15, 17'b0);

        // Reset state, with mem_ready both low and high while reset is held
        reset = 1'b1;
        mem_ready = 1'b0;
        #12;
        check("rst_state", 32'(state), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_ctl_rdy0", 32'(ctl), 32'(17'b0001000_00_00_00_01_00));
        mem_ready = 1'b1;
        #1;
        check("rst_ctl_rdy1", 32'(ctl), 32'(17'b0001000_00_00_00_01_00));

        // Table-driven instruction sequences with mem_ready held high
        for (int v = 0; v < 13; v++) begin
            opcode = vt[v].op;
            funct = vt[v].fn;
            zero = vt[v].z;
            mem_ready = 1'b1;
            start();
            for (int k = 0; k < vt[v].len; k++) begin
                #1;
                check({vt[v].name, "_state"}, 32'(state), 32'(vt[v].seq[k]));
                if (k == 0)
                    check({vt[v].name, "_fetch_ctl"}, 32'(ctl), 32'(17'b1101000_00_00_00_01_00));
                if (k == vt[v].len - 1)
                    check({vt[v].name, "_ctl"}, 32'(ctl), 32'(vt[v].ctl));
                @(negedge clock);
            end
            #1;
            check({vt[v].name, "_after"}, 32'(state), 32'(vt[v].after));
            check({vt[v].name, "_error"}, 32'(error), 32'(vt[v].after == 4'd15));
        end

        // LW with three not-ready cycles in MEMRD
        lw_seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
        lw_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        opcode = 6'h23;
        funct = 6'h00;
        mem_ready = 1'b1;
        start();
        for (int k = 0; k < 9; k++) begin
            mem_ready = lw_rdy[k];
            #1;
            check("lw_wait_state", 32'(state), 32'(lw_seq[k]));
            if (lw_seq[k] == 4'd3)
                check("lw_wait_rd_iord", 32'({mem_read, iord, mem_write}), 32'(3'b110));
            @(negedge clock);
        end

        // FETCH timeout: 15 not-ready cycles then sticky ERROR
        opcode = 6'h00;
        funct = 6'h20;
        mem_ready = 1'b0;
        start();
        for (int k = 0; k < 15; k++) begin
            #1;
            check("to_fetch_wait", 32'(state), 32'd0);
            @(negedge clock);
        end
        #1;
        check("to_error_state", 32'(state), 32'd15);
        check("to_error_flag", 32'(error), 32'd1);
        check("to_error_ctl", 32'(ctl), 32'd0);
        mem_ready = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check("to_sticky_state", 32'(state), 32'd15);
        check("to_sticky_flag", 32'(error), 32'd1);

        // Ready arriving on the 15th wait cycle completes normally
        mem_ready = 1'b0;
        start();
        for (int k = 0; k < 15; k++) begin
            mem_ready = (k == 14);
            #1;
            check("edge_fetch_wait", 32'(state), 32'd0);
            @(negedge clock);
        end
        #1;
        check("edge_decode", 32'(state), 32'd1);
        check("edge_no_error", 32'(error), 32'd0);

        // Reset asserted between edges while in MEMWR
        opcode = 6'h2B;
        mem_ready = 1'b1;
        start();
        repeat (3) @(negedge clock);
        mem_ready = 1'b0;
        #1;
        check("mwr_state", 32'(state), 32'd5);
        check("mwr_mem_write", 32'(mem_write), 32'd1);
        reset = 1'b1;
        #1;
        check("mwr_rst_mem_write", 32'(mem_write), 32'd0);
        check("mwr_rst_state", 32'(state), 32'd0);
        mem_ready = 1'b1;
        reset = 1'b0;
        @(negedge clock);
        #1;
        check("mwr_post_rst_decode", 32'(state), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: max cycles any memory wait state waits for mem_ready.
REQ-002 SHALL have port clock, input, 1: sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port opcode, input, 6: instruction[31:26] from instruction register.
REQ-005 SHALL have port funct, input, 6: instruction[5:0].
REQ-006 SHALL have port zero, input, 1: ALU zero flag.
REQ-007 SHALL have port mem_ready, input, 1: memory completes the current read/write this cycle.
REQ-008 SHALL have outputs pc_write, ir_write, iord, mem_read, mem_write, reg_write, alu_src_a, each 1 bit.
REQ-009 SHALL have outputs pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op, each 2 bits.
REQ-010 SHALL have outputs state (4 bits) and error (1 bit, sticky fault flag).

Function
REQ-011 SHALL use states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, JR=12, JAL=13, ERROR=15.
REQ-012 SHALL drive all outputs as Moore functions of state, except pc_write, ir_write and wait-state exits, which also depend on mem_ready/zero; unlisted outputs are 0.
REQ-013 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00; when mem_ready=1, ir_write=1, pc_write=1, pc_src=00 (PC+1, word addressed), next DECODE; else stay.
REQ-014 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target); next by opcode: 00 with funct 08 -> JR, other 00 -> EXEC; 23/2B -> MEMADR; 04/05 -> BRANCH; 02 -> JUMP; 03 -> JAL; 08,09,0A,0B,0C,0D,0E,0F -> IEXEC; any other -> ERROR.
REQ-015 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEMRD if opcode 23, else MEMWR.
REQ-016 MEMRD: mem_read=1, iord=1; next MEMWB on mem_ready. MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01; next FETCH.
REQ-017 MEMWR: mem_write=1, iord=1; next FETCH on mem_ready.
REQ-018 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next ALUWB. ALUWB: reg_write=1, reg_dst=01, mem_to_reg=00; next FETCH.
REQ-019 IEXEC: alu_src_a=1, alu_src_b=10, alu_op=11; next IWB. IWB: reg_write=1, reg_dst=00, mem_to_reg=00; next FETCH.
REQ-020 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01; pc_write=1 iff (opcode 04 and zero) or (opcode 05 and !zero); next FETCH.
REQ-021 JUMP: pc_write=1, pc_src=10; next FETCH. JR: pc_write=1, pc_src=11; next FETCH.
REQ-022 JAL: pc_write=1, pc_src=10, reg_write=1, reg_dst=10 ($31), mem_to_reg=10 (PC, already PC+1); next FETCH.
REQ-023 SHALL keep a wait counter cleared on entry to FETCH, MEMRD, MEMWR and incremented each cycle there with mem_ready=0; when it reaches MEM_TIMEOUT with mem_ready=0, next state ERROR.
REQ-024 mem_ready=1 in the same cycle the counter reaches MEM_TIMEOUT SHALL complete normally (ready wins).
REQ-025 ERROR: all strobes 0, error=1, state held until reset; mem_ready ignored.
REQ-026 Latencies with mem_ready constantly 1: R-type/I-ALU 4 cycles, LW 5, SW 4, branch/J/JR/JAL 3.

Reset
REQ-027 reset=1 SHALL immediately (asynchronously) force state=FETCH, counter=0, error=0 and all strobes except FETCH's Moore outputs to 0; mem_write/reg_write/pc_write SHALL drop in the same cycle reset rises.
REQ-028 Reset mid-operation SHALL abandon the instruction; first post-reset rising edge evaluates FETCH.

Verification
REQ-029 ADD (opcode 00, funct 20), mem_ready=1 -> states 0,1,6,7,0; reg_write=1, reg_dst=01 only in state 7.
REQ-030 LW (23) with mem_ready low 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4,0; mem_read, iord=1 throughout MEMRD.
REQ-031 BEQ (04) zero=1 -> pc_write=1, pc_src=01 in state 8; repeat with zero=0 -> pc_write=0; BNE inverse.
REQ-032 JAL (03) -> state 13 one cycle: pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10.
REQ-033 mem_ready held 0 in FETCH -> ERROR after 15 wait cycles, error=1 sticky; ready=1 at cycle 15 -> DECODE instead; opcode 3F -> ERROR from DECODE.
REQ-034 reset asserted mid-MEMWR between edges -> mem_write=0 and state=0 before next edge.
